mem_access_sequencer: RTL

- Multi-cycle data-memory access sequencer between the execute/memory stage and a variable-latency data memory port.
- Takes the decoder's MemEn/MemWrite/ByteEn/TruncSrc plus ALU address and Rs2 data.
- Drives a req/ack memory handshake, stalls the pipeline for the whole access, aligns byte lanes, and truncates/extends load data.
- Faults on misaligned addresses and on a memory that fails to acknowledge.

---
 rtl/mem_access_sequencer_if.sv | 26 ++
 rtl/mem_access_sequencer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mem_access_sequencer_if.sv
// Memory-side bus of the access sequencer: one request with its fields, and the
// completion acknowledgement with read data.
interface mem_access_sequencer_if #(
   parameter int WORD_SIZE = 32
);
   logic                     MemReq;
   logic                     MemWe;
   logic [WORD_SIZE-1:0]     MemAddr;
   logic [WORD_SIZE/8-1:0]   MemBe;
   logic [WORD_SIZE-1:0]     MemWData;
   logic                     MemAck;
   logic [WORD_SIZE-1:0]     MemRData;

   // Handshake: MemReq is held high with all fields stable until the first cycle
   // in which MemAck is sampled high; that cycle completes the access and
   // MemRData is only meaningful in it.
   modport master (
      output MemReq, MemWe, MemAddr, MemBe, MemWData,
      input  MemAck, MemRData
   );

   modport slave (
      input  MemReq, MemWe, MemAddr, MemBe, MemWData,
      output MemAck, MemRData
   );
endinterface

// File: rtl/mem_access_sequencer.sv
// Data-memory access sequencer: stalls the pipeline while a single lane-aligned
// load/store runs over a req/ack port, then delivers the extended load result.
module mem_access_sequencer #(
   parameter int WORD_SIZE      = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   MemEn,
   input  logic                   MemWrite,
   input  logic [3:0]             ByteEn,
   input  logic [2:0]             TruncSrc,
   input  logic [WORD_SIZE-1:0]   Addr,
   input  logic [WORD_SIZE-1:0]   WriteData,
   output logic                   Stall,
   output logic [WORD_SIZE-1:0]   ReadResult,
   output logic                   ResultValid,
   output logic                   MisalignFault,
   output logic                   BusError,
   mem_access_sequencer_if.master mem,
   output logic [1:0]             o_dbg_state
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   localparam logic [2:0] TS_BYTE   = 3'd1;
   localparam logic [2:0] TS_HALF   = 3'd2;
   localparam logic [2:0] TS_BYTE_U = 3'd4;
   localparam logic [2:0] TS_HALF_U = 3'd5;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                 r_state;
   state_t                 w_next;
   logic                   w_stall;
   logic                   w_timeout;
   logic [3:0]             w_load_mask;
   logic [3:0]             w_mask;
   logic                   w_misaligned;

   logic                   r_req;
   logic                   r_we;
   logic [WORD_SIZE-1:0]   r_addr;
   logic [3:0]             r_be;
   logic [WORD_SIZE-1:0]   r_wdata;
   logic [1:0]             r_off;
   logic [2:0]             r_tsrc;
   logic [CNT_W-1:0]       r_cnt;
   logic [WORD_SIZE-1:0]   r_read_result;
   logic                   r_result_valid;
   logic                   r_misalign;
   logic                   r_bus_error;

   // Shift the addressed lane down to bit 0, then sign/zero extend by size.
   function automatic logic [WORD_SIZE-1:0] f_extend(
      input logic [WORD_SIZE-1:0] word,
      input logic [1:0]           off,
      input logic [2:0]           tsrc
   );
      logic [WORD_SIZE-1:0] sh;
      sh = word >> {off, 3'b000};
      case (tsrc)
         TS_BYTE:   f_extend = {{(WORD_SIZE-8){sh[7]}}, sh[7:0]};
         TS_HALF:   f_extend = {{(WORD_SIZE-16){sh[15]}}, sh[15:0]};
         TS_BYTE_U: f_extend = {{(WORD_SIZE-8){1'b0}}, sh[7:0]};
         TS_HALF_U: f_extend = {{(WORD_SIZE-16){1'b0}}, sh[15:0]};
         default:   f_extend = sh;
      endcase
   endfunction

   always_comb begin
      w_load_mask = 4'b1111;
      case (TruncSrc)
         TS_BYTE, TS_BYTE_U: w_load_mask = 4'b0001;
         TS_HALF, TS_HALF_U: w_load_mask = 4'b0011;
         default:            w_load_mask = 4'b1111;
      endcase
   end

   assign w_mask       = MemWrite ? ByteEn : w_load_mask;
   assign w_misaligned = ((w_mask[3] | w_mask[2]) && (Addr[1:0] != 2'b00)) ||
                         (w_mask[1] && Addr[0]);

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      w_stall   = 1'b0;
      w_timeout = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (MemEn) begin
               if (w_misaligned) begin
                  w_next = S_DONE;
               end else begin
                  w_next  = S_BUSY;
                  w_stall = 1'b1;
               end
            end
         end
         S_BUSY: begin
            w_stall = 1'b1;
            // An ack in the final allowed cycle still completes the access.
            if (mem.MemAck) begin
               w_next = S_DONE;
            end else if (r_cnt == CNT_LAST) begin
               w_next    = S_DONE;
               w_timeout = 1'b1;
            end
         end
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_req          <= 1'b0;
         r_we           <= 1'b0;
         r_addr         <= '0;
         r_be           <= '0;
         r_wdata        <= '0;
         r_off          <= '0;
         r_tsrc         <= '0;
         r_cnt          <= '0;
         r_read_result  <= '0;
         r_result_valid <= 1'b0;
         r_misalign     <= 1'b0;
         r_bus_error    <= 1'b0;
      end else begin
         r_misalign  <= 1'b0;
         r_bus_error <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (MemEn && !w_misaligned) begin
                  r_req   <= 1'b1;
                  r_we    <= MemWrite;
                  r_addr  <= {Addr[WORD_SIZE-1:2], 2'b00};
                  r_be    <= w_mask << Addr[1:0];
                  r_wdata <= WriteData << {Addr[1:0], 3'b000};
                  r_off   <= Addr[1:0];
                  r_tsrc  <= TruncSrc;
                  r_cnt   <= '0;
               end else if (MemEn) begin
                  r_misalign <= 1'b1;
               end
            end
            S_BUSY: begin
               r_cnt <= r_cnt + CNT_W'(1);
               if (mem.MemAck) begin
                  r_req          <= 1'b0;
                  r_we           <= 1'b0;
                  r_result_valid <= ~r_we;
                  r_read_result  <= r_we ? '0 : f_extend(mem.MemRData, r_off, r_tsrc);
               end else if (w_timeout) begin
                  r_req       <= 1'b0;
                  r_we        <= 1'b0;
                  r_bus_error <= 1'b1;
               end
            end
            S_DONE: begin
               r_result_valid <= 1'b0;
               r_read_result  <= '0;
            end
            default: begin
               r_req <= 1'b0;
               r_we  <= 1'b0;
            end
         endcase
      end
   end

   assign Stall         = w_stall & ~reset;
   assign ReadResult    = r_read_result;
   assign ResultValid   = r_result_valid;
   assign MisalignFault = r_misalign;
   assign BusError      = r_bus_error;
   assign o_dbg_state   = r_state;

   assign mem.MemReq   = r_req;
   assign mem.MemWe    = r_we;
   assign mem.MemAddr  = r_addr;
   assign mem.MemBe    = r_be;
   assign mem.MemWData = r_wdata;

endmodule
